mult_reuse_sched: RTL and testbench

Sequencer for the multiplier-reuse stage (NFU-2A/2B). Accepts a stream of per-step reuse descriptors and, for a tile of a programmed number of steps, drives the level-1/level-2 mux select lines and the per-lane reuse-buffer read/write addresses and write enables. It maintains a ring write pointer per lane, so each descriptor names stored products by age rather than by absolute slot. It also tracks the stage pipeline so a tile's final results can be flagged and completion signalled.

---
 rtl/mult_reuse_sched_pkg.sv | 25 ++
 rtl/mult_reuse_sched_if.sv | 55 +++++
 rtl/mult_reuse_sched_reuse_wr_ptr.sv | 33 +++
 rtl/mult_reuse_sched.sv | 135 +++++++++++++
 tb/tb_mult_reuse_sched.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_reuse_sched_pkg.sv
// Shared types, default widths and lane slicing helpers for the
// multiplier-reuse sequencer.
package mult_reuse_sched_pkg;

  localparam int DEF_TN           = 16;
  localparam int DEF_OUT_LIMIT    = 2;
  localparam int DEF_IN_LIMIT     = 3;
  localparam int DEF_L1_SEL_WIDTH = 4;
  localparam int DEF_L2_SEL_WIDTH = 6;
  localparam int DEF_ADDR_SIZE    = 2;
  localparam int DEF_PIPE_DEPTH   = 2;
  localparam int STEP_W           = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  // Low bit of a lane's field inside a flattened per-lane bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mult_reuse_sched_if.sv
// Descriptor / control bus between the reuse sequencer and its producer
// and consumers.
interface mult_reuse_sched_if
  import mult_reuse_sched_pkg::*;
#(
  parameter int Tn           = DEF_TN,
  parameter int OUT_LIMIT    = DEF_OUT_LIMIT,
  parameter int IN_LIMIT     = DEF_IN_LIMIT,
  parameter int L1_SEL_WIDTH = DEF_L1_SEL_WIDTH,
  parameter int L2_SEL_WIDTH = DEF_L2_SEL_WIDTH,
  parameter int ADDR_SIZE    = DEF_ADDR_SIZE
);

  localparam int L1_W = Tn * OUT_LIMIT * L1_SEL_WIDTH;
  localparam int L2_W = Tn * IN_LIMIT * L2_SEL_WIDTH;
  localparam int AD_W = Tn * ADDR_SIZE;

  logic              i_start;
  logic [STEP_W-1:0] i_num_steps;
  logic              i_stall;
  logic              i_desc_valid;
  logic              o_desc_ready;
  logic [L1_W-1:0]   i_desc_l1;
  logic [L2_W-1:0]   i_desc_l2;
  logic [AD_W-1:0]   i_desc_rd_age;
  logic [Tn-1:0]     i_desc_store;
  logic              i_desc_last;
  logic [L1_W-1:0]   o_l1_sel_lines;
  logic [L2_W-1:0]   o_l2_sel_lines;
  logic [AD_W-1:0]   o_buf_read_addr;
  logic [AD_W-1:0]   o_buf_write_addr;
  logic [Tn-1:0]     o_write_en;
  logic              o_issue_valid;
  logic              o_out_valid;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  modport master (
    output i_start, i_num_steps, i_stall, i_desc_valid, i_desc_l1, i_desc_l2,
           i_desc_rd_age, i_desc_store, i_desc_last,
    input  o_desc_ready, o_l1_sel_lines, o_l2_sel_lines, o_buf_read_addr,
           o_buf_write_addr, o_write_en, o_issue_valid, o_out_valid, o_busy,
           o_done, o_err
  );

  modport slave (
    input  i_start, i_num_steps, i_stall, i_desc_valid, i_desc_l1, i_desc_l2,
           i_desc_rd_age, i_desc_store, i_desc_last,
    output o_desc_ready, o_l1_sel_lines, o_l2_sel_lines, o_buf_read_addr,
           o_buf_write_addr, o_write_en, o_issue_valid, o_out_valid, o_busy,
           o_done, o_err
  );

endinterface

// File: rtl/mult_reuse_sched_reuse_wr_ptr.sv
// Per-lane ring write pointer; turns a product age (0 = newest) into an
// absolute reuse-buffer slot relative to the current write position.
module reuse_wr_ptr
  import mult_reuse_sched_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [ADDR_SIZE-1:0] age,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [ADDR_SIZE-1:0] rd_addr
);

  logic [ADDR_SIZE-1:0] wp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
    end else if (clear) begin
      wp <= '0;
    end else if (advance) begin
      wp <= wp + ADDR_SIZE'(1);
    end
  end

  // Newest stored product sits one slot behind wp; modular wrap is free.
  assign wr_addr = wp;
  assign rd_addr = wp - ADDR_SIZE'(1) - age;

endmodule

// File: rtl/mult_reuse_sched.sv
// Multiplier-reuse stage sequencer: issues one descriptor per step of a tile,
// drives mux selects and reuse-buffer addresses, and signals tile completion.
module mult_reuse_sched
  import mult_reuse_sched_pkg::*;
#(
  parameter int Tn           = DEF_TN,
  parameter int OUT_LIMIT    = DEF_OUT_LIMIT,
  parameter int IN_LIMIT     = DEF_IN_LIMIT,
  parameter int L1_SEL_WIDTH = DEF_L1_SEL_WIDTH,
  parameter int L2_SEL_WIDTH = DEF_L2_SEL_WIDTH,
  parameter int ADDR_SIZE    = DEF_ADDR_SIZE,
  parameter int PIPE_DEPTH   = DEF_PIPE_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_reuse_sched_if.slave   bus
);

  localparam int L1_W = Tn * OUT_LIMIT * L1_SEL_WIDTH;
  localparam int L2_W = Tn * IN_LIMIT * L2_SEL_WIDTH;
  localparam int AD_W = Tn * ADDR_SIZE;
  // Every valid stage except the output one; empty means o_out_valid is the last.
  localparam logic [PIPE_DEPTH-1:0] PEND_MASK = {PIPE_DEPTH{1'b1}} >> 1;

  state_t            state;
  logic [STEP_W-1:0] num_steps_q;
  logic [STEP_W-1:0] step_cnt;
  logic [PIPE_DEPTH-1:0] vld_sr;
  logic [L1_W-1:0]   l1_q;
  logic [L2_W-1:0]   l2_q;
  logic [AD_W-1:0]   rd_q;
  logic [AD_W-1:0]   wr_q;
  logic [Tn-1:0]     we_q;
  logic              iv_q;
  logic              done_q;
  logic              err_q;

  logic              desc_ready;
  logic              issue;
  logic              ptr_clear;
  logic              final_step;
  logic [AD_W-1:0]   rd_addr;
  logic [AD_W-1:0]   wr_addr;

  assign desc_ready = (state == S_RUN) && !bus.i_stall;
  assign issue      = desc_ready && bus.i_desc_valid;
  assign ptr_clear  = (state == S_IDLE) && bus.i_start;
  assign final_step = (step_cnt == num_steps_q - STEP_W'(1));

  for (genvar i = 0; i < Tn; i++) begin : g_lane
    reuse_wr_ptr #(.ADDR_SIZE(ADDR_SIZE)) u_ptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (ptr_clear),
      .advance (issue && bus.i_desc_store[i]),
      .age     (bus.i_desc_rd_age[lane_lo(i, ADDR_SIZE) +: ADDR_SIZE]),
      .wr_addr (wr_addr[lane_lo(i, ADDR_SIZE) +: ADDR_SIZE]),
      .rd_addr (rd_addr[lane_lo(i, ADDR_SIZE) +: ADDR_SIZE])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath output registers are reset too, so every output reads 0 out of reset.
      state       <= S_IDLE;
      num_steps_q <= '0;
      step_cnt    <= '0;
      vld_sr      <= '0;
      l1_q        <= '0;
      l2_q        <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      we_q        <= '0;
      iv_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      iv_q   <= issue;
      we_q   <= issue ? bus.i_desc_store : '0;
      vld_sr <= (vld_sr << 1) | PIPE_DEPTH'(iv_q);
      done_q <= 1'b0;

      if (issue) begin
        l1_q <= bus.i_desc_l1;
        l2_q <= bus.i_desc_l2;
        rd_q <= rd_addr;
        wr_q <= wr_addr;
      end

      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            num_steps_q <= bus.i_num_steps;
            step_cnt    <= '0;
            err_q       <= 1'b0;
            state       <= (bus.i_num_steps == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            step_cnt <= step_cnt + STEP_W'(1);
            if (final_step) begin
              state <= S_DRAIN;
              if (!bus.i_desc_last) err_q <= 1'b1;
            end else if (bus.i_desc_last) begin
              state <= S_DRAIN;
              err_q <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!iv_q && ((vld_sr & PEND_MASK) == '0)) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_desc_ready     = desc_ready;
  assign bus.o_l1_sel_lines   = l1_q;
  assign bus.o_l2_sel_lines   = l2_q;
  assign bus.o_buf_read_addr  = rd_q;
  assign bus.o_buf_write_addr = wr_q;
  assign bus.o_write_en       = we_q;
  assign bus.o_issue_valid    = iv_q;
  assign bus.o_out_valid      = vld_sr[PIPE_DEPTH-1];
  assign bus.o_busy           = (state != S_IDLE);
  assign bus.o_done           = done_q;
  assign bus.o_err            = err_q;

endmodule

// File: tb/tb_mult_reuse_sched.sv
// Self-checking bench for mult_reuse_sched: randomized descriptors checked
// every cycle against a step-level reference model, plus directed scenarios.
module tb_mult_reuse_sched;

  localparam int TN   = 16;
  localparam int OL   = 2;
  localparam int IL   = 3;
  localparam int L1S  = 4;
  localparam int L2S  = 6;
  localparam int AS   = 2;
  localparam int PD   = 2;
  localparam int NB   = 1 << AS;
  localparam int L1_W = TN * OL * L1S;
  localparam int L2_W = TN * IL * L2S;
  localparam int AD_W = TN * AS;
  localparam int CW   = 512;

  logic clk;
  logic rst_n;

  mult_reuse_sched_if #(
    .Tn(TN), .OUT_LIMIT(OL), .IN_LIMIT(IL),
    .L1_SEL_WIDTH(L1S), .L2_SEL_WIDTH(L2S), .ADDR_SIZE(AS)
  ) bus ();

  mult_reuse_sched #(
    .Tn(TN), .OUT_LIMIT(OL), .IN_LIMIT(IL),
    .L1_SEL_WIDTH(L1S), .L2_SEL_WIDTH(L2S), .ADDR_SIZE(AS), .PIPE_DEPTH(PD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: tile phase, per-lane ring positions, held outputs.
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_e;
  mstate_e         m_st;
  int              m_steps;
  int              m_issued;
  bit              m_err;
  bit              m_done;
  bit              m_iv;
  bit              m_ov;
  bit              hist[PD+1];
  int              wp[TN];
  logic [L1_W-1:0] e_l1;
  logic [L2_W-1:0] e_l2;
  logic [AD_W-1:0] e_rd;
  logic [AD_W-1:0] e_wr;
  logic [TN-1:0]   e_we;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_steps = 0; m_issued = 0;
    m_err = 0; m_done = 0; m_iv = 0; m_ov = 0;
    for (int k = 0; k <= PD; k++) hist[k] = 0;
    for (int i = 0; i < TN; i++) wp[i] = 0;
    e_l1 = '0; e_l2 = '0; e_rd = '0; e_wr = '0; e_we = '0;
  endtask

  // Applies the sampled inputs of one rising edge to the model.
  task automatic model_edge();
    bit iss;
    bit clear;
    iss = (m_st == M_RUN) && !bus.i_stall && bus.i_desc_valid;
    m_iv = iss;
    e_we = iss ? bus.i_desc_store : '0;
    if (iss) begin
      e_l1 = bus.i_desc_l1;
      e_l2 = bus.i_desc_l2;
      for (int i = 0; i < TN; i++) begin
        int age = int'(bus.i_desc_rd_age[i*AS +: AS]);
        e_wr[i*AS +: AS] = AS'(wp[i]);
        e_rd[i*AS +: AS] = AS'(((wp[i] - 1 - age) % NB + NB) % NB);
        if (bus.i_desc_store[i]) wp[i] = (wp[i] + 1) % NB;
      end
    end
    for (int k = PD; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = m_iv;
    m_ov = hist[PD];
    m_done = 0;
    case (m_st)
      M_IDLE: if (bus.i_start) begin
        m_steps = int'(bus.i_num_steps);
        m_issued = 0;
        m_err = 0;
        for (int i = 0; i < TN; i++) wp[i] = 0;
        m_st = (m_steps == 0) ? M_DRAIN : M_RUN;
      end
      M_RUN: if (iss) begin
        m_issued++;
        if (m_issued == m_steps) begin
          m_st = M_DRAIN;
          if (!bus.i_desc_last) m_err = 1;
        end else if (bus.i_desc_last) begin
          m_err = 1;
          m_st = M_DRAIN;
        end
      end
      M_DRAIN: begin
        clear = 1;
        for (int k = 0; k <= PD; k++) if (hist[k]) clear = 0;
        if (clear) begin
          m_done = 1;
          m_st = M_IDLE;
        end
      end
      default: m_st = M_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    check("l1_sel",   CW'(bus.o_l1_sel_lines),   CW'(e_l1));
    check("l2_sel",   CW'(bus.o_l2_sel_lines),   CW'(e_l2));
    check("rd_addr",  CW'(bus.o_buf_read_addr),  CW'(e_rd));
    check("wr_addr",  CW'(bus.o_buf_write_addr), CW'(e_wr));
    check("write_en", CW'(bus.o_write_en),       CW'(e_we));
    check("issue_v",  CW'(bus.o_issue_valid),    CW'(m_iv));
    check("out_v",    CW'(bus.o_out_valid),      CW'(m_ov));
    check("busy",     CW'(bus.o_busy),           CW'(m_st != M_IDLE));
    check("done",     CW'(bus.o_done),           CW'(m_done));
    check("err",      CW'(bus.o_err),            CW'(m_err));
  endtask

  task automatic cycle();
    #1;
    check("desc_ready", CW'(bus.o_desc_ready), CW'((m_st == M_RUN) && !bus.i_stall));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  function automatic logic [TN-1:0] rand_store();
    logic [TN-1:0] v;
    for (int b = 0; b < TN; b++) v[b] = ($urandom_range(0, 1) != 0);
    return v;
  endfunction

  function automatic logic [AD_W-1:0] rand_age();
    logic [AD_W-1:0] v;
    for (int b = 0; b < AD_W; b++) v[b] = ($urandom_range(0, 1) != 0);
    return v;
  endfunction

  task automatic drive(input bit valid, input bit last, input logic [TN-1:0] store,
                       input logic [AD_W-1:0] age);
    bus.i_desc_valid  = valid;
    bus.i_desc_last   = last;
    bus.i_desc_store  = store;
    bus.i_desc_rd_age = age;
    for (int b = 0; b < L1_W; b++) bus.i_desc_l1[b] = ($urandom_range(0, 1) != 0);
    for (int b = 0; b < L2_W; b++) bus.i_desc_l2[b] = ($urandom_range(0, 1) != 0);
  endtask

  task automatic start_tile(input int n);
    bus.i_start = 1'b1;
    bus.i_num_steps = 16'(n);
    drive(1'b0, 1'b0, rand_store(), rand_age());
    cycle();
    bus.i_start = 1'b0;
  endtask

  task automatic finish_tile();
    int k = 0;
    bus.i_desc_valid = 1'b0;
    bus.i_stall = 1'b0;
    while (m_st != M_IDLE && k < 100) begin
      cycle();
      k++;
    end
    check("finish_bound", CW'(bus.o_busy), CW'(0));
  endtask

  // Full tile with random descriptors; stall forced for 2 cycles from stall_from.
  task automatic run_tile(input int n, input int last_at, input int stall_pct,
                          input int gap_pct, input int stall_from,
                          output int done_at, output int ov_cnt);
    int cyc;
    done_at = -1;
    ov_cnt = 0;
    start_tile(n);
    cyc = 1;
    while (m_st != M_IDLE && cyc < 300) begin
      bus.i_stall = ($urandom_range(0, 99) < stall_pct) ||
                    (cyc >= stall_from && cyc < stall_from + 2);
      drive($urandom_range(0, 99) >= gap_pct, (m_issued + 1) == last_at,
            rand_store(), rand_age());
      cycle();
      cyc++;
      if (bus.o_out_valid) ov_cnt++;
      if (bus.o_done && done_at < 0) done_at = cyc;
    end
    bus.i_desc_valid = 1'b0;
    bus.i_stall = 1'b0;
    check("tile_bound", CW'(bus.o_busy), CW'(0));
  endtask

  int wrap_wr[5] = '{0, 1, 2, 3, 0};
  int wrap_rd[5] = '{3, 0, 1, 2, 3};

  initial begin
    int done_at;
    int ov_cnt;
    logic [TN-1:0]   st;
    logic [AD_W-1:0] ag;

    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_num_steps = '0;
    bus.i_stall = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    model_reset();
    #1;
    check_outputs();
    check("rst_ready", CW'(bus.o_desc_ready), CW'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic 4-step tile, back to back.
    run_tile(4, 4, 0, 0, 1000, done_at, ov_cnt);
    check("basic_done_at", CW'(done_at), CW'(8));
    check("basic_ov_cnt", CW'(ov_cnt), CW'(4));
    check("basic_err", CW'(bus.o_err), CW'(0));

    // Lane 0 ring wrap with age 0.
    start_tile(5);
    for (int s = 0; s < 5; s++) begin
      st = rand_store(); st[0] = 1'b1;
      ag = rand_age();   ag[AS-1:0] = '0;
      drive(1'b1, s == 4, st, ag);
      cycle();
      check("wrap_wr", CW'(bus.o_buf_write_addr[AS-1:0]), CW'(wrap_wr[s]));
      check("wrap_rd", CW'(bus.o_buf_read_addr[AS-1:0]), CW'(wrap_rd[s]));
    end
    finish_tile();

    // Age lookup without store.
    start_tile(4);
    for (int s = 0; s < 4; s++) begin
      st = rand_store(); st[0] = (s < 3);
      ag = rand_age();
      if (s == 3) ag[AS-1:0] = AS'(2);
      drive(1'b1, s == 3, st, ag);
      cycle();
    end
    check("age_rd", CW'(bus.o_buf_read_addr[AS-1:0]), CW'(0));
    check("age_we", CW'(bus.o_write_en[0]), CW'(0));
    check("age_wr", CW'(bus.o_buf_write_addr[AS-1:0]), CW'(3));
    finish_tile();

    // Two-cycle stall mid-tile delays completion by two cycles.
    run_tile(4, 4, 0, 0, 3, done_at, ov_cnt);
    check("stall_done_at", CW'(done_at), CW'(10));
    check("stall_ov_cnt", CW'(ov_cnt), CW'(4));

    // Early last marker.
    run_tile(5, 2, 0, 0, 1000, done_at, ov_cnt);
    check("early_err", CW'(bus.o_err), CW'(1));
    check("early_done_seen", CW'(done_at > 0), CW'(1));
    check("early_ov_cnt", CW'(ov_cnt), CW'(2));

    // Random tiles with stalls and gaps.
    for (int t = 0; t < 5; t++) begin
      int n = $urandom_range(1, 8);
      run_tile(n, n, 20, 25, 1000, done_at, ov_cnt);
      check("rand_ov_cnt", CW'(ov_cnt), CW'(n));
      check("rand_err", CW'(bus.o_err), CW'(0));
    end

    // Asynchronous reset in the middle of a tile.
    start_tile(6);
    for (int s = 0; s < 2; s++) begin
      drive(1'b1, 1'b0, rand_store(), rand_age());
      cycle();
    end
    drive(1'b1, 1'b0, rand_store(), rand_age());
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check("rst_mid_busy", CW'(bus.o_busy), CW'(0));
    @(posedge clk);
    #1;
    check("rst_hold_done", CW'(bus.o_done), CW'(0));
    rst_n = 1'b1;
    bus.i_desc_valid = 1'b0;

    // Start while busy is ignored.
    start_tile(3);
    bus.i_start = 1'b1;
    bus.i_num_steps = 16'(1);
    drive(1'b1, 1'b0, rand_store(), rand_age());
    cycle();
    bus.i_start = 1'b0;
    for (int s = 1; s < 3; s++) begin
      drive(1'b1, s == 2, rand_store(), rand_age());
      cycle();
    end
    check("busy_start_err", CW'(bus.o_err), CW'(0));
    finish_tile();

    // Zero-step tile: done two cycles after start.
    start_tile(0);
    check("zero_busy", CW'(bus.o_busy), CW'(1));
    cycle();
    check("zero_done", CW'(bus.o_done), CW'(1));
    check("zero_err", CW'(bus.o_err), CW'(0));
    cycle();
    check("zero_idle", CW'(bus.o_busy), CW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
